// File: rtl/vec_alu_issue_if.sv
// Bundled signal set between the vector ALU issue stage, its instruction source,
// the four-lane ALU controller and the register-file write port.
interface vec_alu_issue_if #(
  parameter int DATA_W = 32
);
  // Instruction handshake: a transfer happens on a rising clk edge where
  // inst_valid and inst_ready are both 1. The source holds inst_op/inst_rd
  // stable while inst_valid is high and unaccepted; inst_ready never depends
  // on inst_valid.
  logic              inst_valid;
  logic              inst_ready;
  logic [3:0]        inst_op;
  logic [3:0]        inst_rd;

  logic              alu_start;
  logic [3:0]        alu_op;
  logic              alu_rdy;
  logic [DATA_W-1:0] alu_result;

  logic              wb_en;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              busy;
  logic              illegal_op;
  logic              timeout_err;
  logic              err_clr;

  modport slave (
    input  inst_valid, inst_op, inst_rd, alu_rdy, alu_result, err_clr,
    output inst_ready, alu_start, alu_op, wb_en, wb_rd, wb_data,
           busy, illegal_op, timeout_err
  );

  modport master (
    output inst_valid, inst_op, inst_rd, alu_rdy, alu_result, err_clr,
    input  inst_ready, alu_start, alu_op, wb_en, wb_rd, wb_data,
           busy, illegal_op, timeout_err
  );
endinterface

// File: rtl/vec_alu_issue.sv
// Vector ALU issue stage: accepts one decoded instruction at a time, starts the
// ALU controller, waits (bounded) for completion and writes the result back.
module vec_alu_issue #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  vec_alu_issue_if.slave      bus,
  output logic [1:0]          dbg_state
);

  // IDLE is encoded as 0 so dbg_state != 0 is exactly "busy".
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          alu_op_q;
  logic [3:0]          wb_rd_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                illegal_q;
  logic                terr_q;

  logic                accept;
  logic                op_bad;
  logic                rdy_hit;
  logic                to_hit;

  logic                inst_ready_c;
  logic                alu_start_c;
  logic                wb_en_c;
  logic                busy_c;

  // Opcodes 1110 and 1111 are the only illegal encodings.
  assign op_bad  = &bus.inst_op[3:1];
  assign accept  = bus.inst_valid && (state_q == S_IDLE);
  assign rdy_hit = (state_q == S_WAIT) && bus.alu_rdy;
  // cnt_q counts completed WAIT cycles, so CNT_LAST marks the TIMEOUT-th one.
  assign to_hit  = (state_q == S_WAIT) && !bus.alu_rdy && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && !op_bad) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (rdy_hit) begin
          state_d = S_WB;
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_ready_c = 1'b0;
    alu_start_c  = 1'b0;
    wb_en_c      = 1'b0;
    busy_c       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  inst_ready_c = 1'b1;
      S_ISSUE: alu_start_c  = 1'b1;
      S_WAIT:  ;
      S_WB:    wb_en_c      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // alu_op is only reloaded in IDLE, which keeps it stable for the whole
  // operation while the controller decodes it combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op_q  <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && op_bad;
      if (accept && !op_bad) begin
        alu_op_q <= bus.inst_op;
        wb_rd_q  <= bus.inst_rd;
      end
      if (rdy_hit) begin
        wb_data_q <= bus.alu_result;
      end
    end
  end

  // A timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      terr_q <= 1'b0;
    end else if (to_hit) begin
      terr_q <= 1'b1;
    end else if (bus.err_clr) begin
      terr_q <= 1'b0;
    end
  end

  assign bus.inst_ready  = inst_ready_c;
  assign bus.alu_start   = alu_start_c;
  assign bus.alu_op      = alu_op_q;
  assign bus.wb_en       = wb_en_c;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.busy        = busy_c;
  assign bus.illegal_op  = illegal_q;
  assign bus.timeout_err = terr_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_vec_alu_issue.sv
// Self-checking bench for vec_alu_issue: directed corner cases plus randomized
// transactions checked against a transaction-level model and write-back scoreboard.
module tb_vec_alu_issue;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int W       = DATA_W + 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vec_alu_issue_if #(.DATA_W(DATA_W)) bus ();
  logic [1:0] dbg_state;

  vec_alu_issue #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  logic [W-1:0]      exp_q[$];
  logic [3:0]        exp_alu_op   = '0;
  logic [3:0]        exp_wb_rd    = '0;
  logic [DATA_W-1:0] exp_wb_data  = '0;
  logic              exp_terr     = 1'b0;
  int                issues       = 0;
  int                wb_expected  = 0;
  int                starts_seen  = 0;
  int                wb_seen      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy_vs_dbg_state", bus.busy, dbg_state != 2'd0);
      if (bus.alu_start) starts_seen++;
      if (bus.wb_en) begin
        wb_seen++;
        chk("wb_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("wb_rd_data", {bus.wb_rd, bus.wb_data}, exp_q.pop_front());
      end
    end
  end

  // driver: one instruction; dly is the WAIT cycle (1-based) on which alu_rdy rises
  task automatic do_inst(input logic [3:0] op, input logic [3:0] rd, input int dly,
                         input logic [DATA_W-1:0] res, input bit hold,
                         input logic [3:0] nop, input logic [3:0] nrd, input bit clr_at_to);
    chk("ready_in_idle", bus.inst_ready, 1);
    bus.inst_valid = 1'b1;
    bus.inst_op    = op;
    bus.inst_rd    = rd;
    @(negedge clk);
    if (hold) begin
      bus.inst_op = nop;
      bus.inst_rd = nrd;
    end else begin
      bus.inst_valid = 1'b0;
    end
    if (op >= 4'd14) begin
      chk("illegal_pulse", bus.illegal_op, 1);
      chk("illegal_no_start", bus.alu_start, 0);
      chk("illegal_not_busy", bus.busy, 0);
      chk("illegal_alu_op_kept", bus.alu_op, exp_alu_op);
      chk("illegal_wb_rd_kept", bus.wb_rd, exp_wb_rd);
      if (!hold) begin
        @(negedge clk);
        chk("illegal_one_cycle", bus.illegal_op, 0);
      end
      return;
    end
    exp_alu_op = op;
    exp_wb_rd  = rd;
    issues++;
    bus.alu_rdy    = 1'($urandom_range(0, 1));
    bus.alu_result = $urandom;
    chk("issue_start", bus.alu_start, 1);
    chk("issue_alu_op", bus.alu_op, op);
    chk("issue_busy", bus.busy, 1);
    chk("issue_not_ready", bus.inst_ready, 0);
    for (int w = 1; w <= TIMEOUT; w++) begin
      @(negedge clk);
      bus.alu_rdy    = (w == dly);
      bus.alu_result = (w == dly) ? res : $urandom;
      bus.err_clr    = clr_at_to && (w == TIMEOUT);
      chk("wait_no_start", bus.alu_start, 0);
      chk("wait_alu_op_held", bus.alu_op, op);
      chk("wait_no_wb", bus.wb_en, 0);
      chk("wait_busy", bus.busy, 1);
      if (w == dly) begin
        exp_q.push_back({rd, res});
        exp_wb_data = res;
        wb_expected++;
        break;
      end
    end
    @(negedge clk);
    bus.alu_rdy    = 1'($urandom_range(0, 1));
    bus.alu_result = $urandom;
    bus.err_clr    = 1'b0;
    if (dly <= TIMEOUT) begin
      chk("wb_pulse", bus.wb_en, 1);
      chk("wb_busy", bus.busy, 1);
      chk("wb_alu_op_held", bus.alu_op, op);
      @(negedge clk);
      bus.alu_rdy = 1'b0;
    end else begin
      exp_terr = 1'b1;
    end
    chk("idle_no_wb", bus.wb_en, 0);
    chk("idle_not_busy", bus.busy, 0);
    chk("idle_ready", bus.inst_ready, 1);
    chk("timeout_err", bus.timeout_err, exp_terr);
    chk("wb_data_kept", bus.wb_data, exp_wb_data);
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_terr = 1'b0;
    chk("err_clr", bus.timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_valid = 1'b0;
    bus.inst_op    = '0;
    bus.inst_rd    = '0;
    bus.alu_rdy    = 1'b0;
    bus.alu_result = '0;
    bus.err_clr    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", bus.inst_ready, 1);

    // basic op, result on 3rd WAIT cycle
    do_inst(4'b1010, 4'd3, 3, 32'h0000_00FF, 1'b0, 4'd0, 4'd0, 1'b0);
    // illegal opcodes
    do_inst(4'b1111, 4'd5, 1, '0, 1'b0, 4'd0, 4'd0, 1'b0);
    do_inst(4'b1110, 4'd6, 1, '0, 1'b0, 4'd0, 4'd0, 1'b0);
    // second instruction held valid while busy
    do_inst(4'h2, 4'd7, 2, $urandom, 1'b1, 4'h5, 4'd9, 1'b0);
    do_inst(4'h5, 4'd9, 4, $urandom, 1'b0, 4'd0, 4'd0, 1'b0);
    // timeout, then clear
    do_inst(4'h1, 4'd2, TIMEOUT + 5, $urandom, 1'b0, 4'd0, 4'd0, 1'b0);
    clear_err();
    // ready exactly on the last permitted WAIT cycle
    do_inst(4'h4, 4'd8, TIMEOUT, $urandom, 1'b0, 4'd0, 4'd0, 1'b0);
    // ready one cycle too late, with err_clr colliding with the set
    do_inst(4'h6, 4'd1, TIMEOUT + 1, $urandom, 1'b0, 4'd0, 4'd0, 1'b1);
    clear_err();

    for (int i = 0; i < 40; i++) begin
      do_inst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              $urandom_range(1, TIMEOUT + 2), $urandom, 1'b0, 4'd0, 4'd0, 1'b0);
      if (exp_terr && $urandom_range(0, 1) == 1) clear_err();
    end

    // reset in WAIT, then a late alu_rdy
    bus.inst_valid = 1'b1;
    bus.inst_op    = 4'h3;
    bus.inst_rd    = 4'd4;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    issues++;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_alu_op  = '0;
    exp_wb_rd   = '0;
    exp_wb_data = '0;
    exp_terr    = 1'b0;
    chk("mid_rst_alu_start", bus.alu_start, 0);
    chk("mid_rst_alu_op", bus.alu_op, exp_alu_op);
    chk("mid_rst_wb_en", bus.wb_en, 0);
    chk("mid_rst_wb_rd", bus.wb_rd, exp_wb_rd);
    chk("mid_rst_wb_data", bus.wb_data, exp_wb_data);
    chk("mid_rst_illegal", bus.illegal_op, 0);
    chk("mid_rst_terr", bus.timeout_err, exp_terr);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    reset_n        = 1'b1;
    bus.alu_rdy    = 1'b1;
    bus.alu_result = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rdy_no_wb", bus.wb_en, 0);
      chk("late_rdy_not_busy", bus.busy, 0);
      chk("late_rdy_wb_data", bus.wb_data, exp_wb_data);
    end
    bus.alu_rdy = 1'b0;
    @(negedge clk);

    chk("start_count", starts_seen, issues);
    chk("wb_count", wb_seen, wb_expected);
    chk("wb_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
